// File: rtl/mem_access.sv
// ============================================================================
//  Module   : mem_access
//  Purpose  : Memory-access pipeline stage. It issues one data-memory request
//             per load or store, aligns and extends load data, aborts on ack
//             timeout, and returns every result as a one-cycle pulse.
//  Options  : MEM_ACCESS_ALIGN_CHECK_EN enables misaligned half/word faults.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        misaligned,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] c_timeout_last = 8'(ACK_TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_timer;
    logic [31:0] r_alu;
    logic [1:0]  r_addr_lo;
    logic [1:0]  r_size;
    logic        r_sign_ext;
    logic        r_is_load;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_align_fault;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

    assign w_accept = in_valid & in_ready;
    assign w_is_mem = mem_read | mem_write;

    // Lane placement for the outgoing request, computed from the live inputs.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'd0;
        case (size)
            2'b00: begin
                w_be    = 4'b0001 << alu_result[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic w_misalign;

    always_comb begin
        w_misalign = 1'b0;
        case (size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = alu_result[0];
            default: w_misalign = |alu_result[1:0];
        endcase
    end

    assign w_align_fault = w_is_mem & w_misalign;
`else
    assign w_align_fault = 1'b0;
`endif

    // Load lane extraction uses the address/size captured at accept time.
    assign w_shifted = dmem_rdata >> {r_addr_lo, 3'b000};

    always_comb begin
        w_load = dmem_rdata;
        case (r_size)
            2'b00:   w_load = {{24{r_sign_ext & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load = r_addr_lo[1]
                              ? {{16{r_sign_ext & dmem_rdata[31]}}, dmem_rdata[31:16]}
                              : {{16{r_sign_ext & dmem_rdata[15]}}, dmem_rdata[15:0]};
            default: w_load = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_timer    <= 8'd0;
            r_alu      <= 32'd0;
            r_addr_lo  <= 2'b00;
            r_size     <= 2'b00;
            r_sign_ext <= 1'b0;
            r_is_load  <= 1'b0;
            in_ready   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'b0000;
            out_valid  <= 1'b0;
            out_data   <= 32'd0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (w_accept) begin
                        in_ready   <= 1'b0;
                        r_alu      <= alu_result;
                        r_addr_lo  <= alu_result[1:0];
                        r_size     <= size;
                        r_sign_ext <= sign_ext;
                        r_is_load  <= mem_read & ~mem_write;
                        if (!w_is_mem) begin
                            r_state   <= RESP;
                            out_valid <= 1'b1;
                            out_data  <= alu_result;
                        end else if (w_align_fault) begin
                            r_state    <= RESP;
                            out_valid  <= 1'b1;
                            out_data   <= 32'd0;
                            misaligned <= 1'b1;
                        end else begin
                            r_state    <= ACCESS;
                            r_timer    <= 8'd0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {alu_result[31:2], 2'b00};
                            dmem_be    <= w_be;
                            dmem_wdata <= w_wdata;
                        end
                    end
                end

                ACCESS: begin
                    if (dmem_ack) begin
                        r_state   <= RESP;
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= r_is_load ? w_load : r_alu;
                    end else if (r_timer == c_timeout_last) begin
                        // Slave never answered: abandon the request and report it.
                        r_state   <= RESP;
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= 32'd0;
                        bus_error <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                RESP: begin
                    r_state    <= IDLE;
                    in_ready   <= 1'b1;
                    out_valid  <= 1'b0;
                    misaligned <= 1'b0;
                    bus_error  <= 1'b0;
                end

                default: begin
                    r_state  <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
//  Module   : tb_mem_access
//  Purpose  : Self-checking bench for mem_access with a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;

    localparam int ACK_TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        out_valid;
    logic [31:0] out_data;
    logic        misaligned;
    logic        bus_error;

    mem_access #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .store_data (store_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .size       (size),
        .sign_ext   (sign_ext),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .misaligned (misaligned),
        .bus_error  (bus_error)
    );

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        berr;
        int          due;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        check_en = 1'b0;
    logic        exp_on = 1'b0;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] last_out;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic [3:0]  last_be;
    logic        last_we;
    logic        last_mis;
    logic        last_berr;
    int          cur_len = 0;
    int          last_len = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- model: what the stage must do, from the op's fields
    function automatic logic model_fault(input logic [31:0] a, input logic memop, input logic [1:0] sz);
        logic f;
        f = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        if (memop && sz == 2'b01) f = (a % 2) != 0;
        if (memop && sz >= 2'b10) f = (a % 4) != 0;
`endif
        return f;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
        int k;
        k = int'(a % 4);
        if (sz == 2'b00) return 4'(1 << k);
        if (sz == 2'b01) return (k >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] sd, input logic [1:0] sz);
        if (sz == 2'b00) return (sd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'b01) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic sx, input logic [31:0] rd);
        int          k;
        logic [31:0] v;
        k = int'(a % 4);
        if (sz == 2'b00) begin
            v = (rd >> (8 * k)) & 32'hFF;
            if (sx && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (rd >> (16 * (k / 2))) & 32'hFFFF;
            if (sx && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- single compare process
    initial forever begin
        exp_t it;
        @(negedge clk);
        if (check_en) begin
            if (exp_on) begin
                chk("dmem_req", {31'd0, dmem_req}, 32'd1);
                chk("dmem_addr", dmem_addr, exp_addr);
                chk("dmem_be", {28'd0, dmem_be}, {28'd0, exp_be});
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, exp_we});
                if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
                chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            end else begin
                chk("dmem_req_quiet", {31'd0, dmem_req}, 32'd0);
            end
            if (dmem_req) begin
                cur_len++;
                last_addr  = dmem_addr;
                last_be    = dmem_be;
                last_we    = dmem_we;
                last_wdata = dmem_wdata;
            end else if (cur_len > 0) begin
                last_len = cur_len;
                cur_len  = 0;
            end
            if (out_valid) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid actual=1 required=0 data=%h", out_data);
                end else begin
                    it = expq.pop_front();
                    chk("out_data", out_data, it.data);
                    chk("misaligned", {31'd0, misaligned}, {31'd0, it.mis});
                    chk("bus_error", {31'd0, bus_error}, {31'd0, it.berr});
                    chk("valid_cycle", cyc, it.due);
                end
                last_out  = out_data;
                last_mis  = misaligned;
                last_berr = bus_error;
            end else begin
                chk("misaligned_idle", {31'd0, misaligned}, 32'd0);
                chk("bus_error_idle", {31'd0, bus_error}, 32'd0);
            end
        end
    end

    // d < 0: never ack; d >= ACK_TIMEOUT: ack arrives after the abort
    task automatic do_op(input logic [31:0] a, input logic [31:0] sd, input logic rd,
                         input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [31:0] rdata, input int d);
        int   n;
        int   c_acc;
        logic memop;
        exp_t it;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        alu_result = a;
        store_data = sd;
        mem_read   = rd;
        mem_write  = wr;
        size       = sz;
        sign_ext   = sx;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        c_acc     = cyc;
        memop     = rd | wr;
        if (!memop) begin
            it = '{data: a, mis: 1'b0, berr: 1'b0, due: c_acc};
            expq.push_back(it);
        end else if (model_fault(a, memop, sz)) begin
            it = '{data: 32'd0, mis: 1'b1, berr: 1'b0, due: c_acc};
            expq.push_back(it);
        end else begin
            exp_addr  = a - (a % 4);
            exp_be    = model_be(a, sz);
            exp_we    = wr;
            exp_wdata = model_wdata(sd, sz);
            exp_on    = 1'b1;
            if (d >= 0 && d < ACK_TIMEOUT) begin
                it = '{data: wr ? a : model_load(a, sz, sx, rdata), mis: 1'b0, berr: 1'b0,
                       due: c_acc + d + 1};
                expq.push_back(it);
                repeat (d) begin
                    @(posedge clk);
                    #1;
                end
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
                @(posedge clk);
                #1;
                dmem_ack = 1'b0;
                exp_on   = 1'b0;
            end else begin
                it = '{data: 32'd0, mis: 1'b0, berr: 1'b1, due: c_acc + ACK_TIMEOUT};
                expq.push_back(it);
                repeat (ACK_TIMEOUT) @(posedge clk);
                #1;
                exp_on = 1'b0;
                if (d >= ACK_TIMEOUT) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                    @(posedge clk);
                    #1;
                    dmem_ack = 1'b0;
                end
            end
        end
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout actual=missing required=out_valid");
            expq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        alu_result = 32'd0;
        store_data = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        size       = 2'b00;
        sign_ext   = 1'b0;
        dmem_rdata = 32'd0;
        dmem_ack   = 1'b0;
        exp_addr   = 32'd0;
        exp_be     = 4'd0;
        exp_we     = 1'b0;
        exp_wdata  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
        rst = 1'b1;
        check_en = 1'b1;

        do_op(32'h0000_1234, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 0);
        chk("pass_through_data", last_out, 32'h0000_1234);

        do_op(32'h0000_0103, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h8000_0000, 3);
        chk("sbyte_addr", last_addr, 32'h0000_0100);
        chk("sbyte_be", {28'd0, last_be}, 32'h8);
        chk("sbyte_data", last_out, 32'hFFFF_FF80);

        do_op(32'h0000_0202, 32'h0000_ABCD, 1'b0, 1'b1, 2'b01, 1'b0, 32'd0, 1);
        chk("hstore_be", {28'd0, last_be}, 32'hC);
        chk("hstore_wdata", last_wdata, 32'hABCD_ABCD);
        chk("hstore_we", {31'd0, last_we}, 32'd1);
        chk("hstore_data", last_out, 32'h0000_0202);

        do_op(32'h0000_0300, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0, -1);
        chk("timeout_len", last_len, 32'd16);
        chk("timeout_berr", {31'd0, last_berr}, 32'd1);
        chk("timeout_data", last_out, 32'd0);

        do_op(32'h0000_0002, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1122_3344, 1);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        chk("misalign_flag", {31'd0, last_mis}, 32'd1);
        chk("misalign_data", last_out, 32'd0);
`else
        chk("noalign_addr", last_addr, 32'd0);
        chk("noalign_be", {28'd0, last_be}, 32'hF);
        chk("noalign_data", last_out, 32'h1122_3344);
`endif

        do_op(32'h0000_0101, 32'd0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_AB00, 0);
        chk("ubyte_data", last_out, 32'h0000_00AB);
        do_op(32'h0000_0206, 32'd0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h8001_0000, 2);
        chk("shalf_data", last_out, 32'hFFFF_8001);
        do_op(32'h0000_0204, 32'd0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h8001_7FFE, 0);
        chk("uhalf_data", last_out, 32'h0000_7FFE);
        do_op(32'h0000_0007, 32'h0000_005A, 1'b0, 1'b1, 2'b00, 1'b0, 32'd0, 0);
        chk("bstore_wdata", last_wdata, 32'h5A5A_5A5A);
        do_op(32'h0000_0500, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'b11, 1'b0, 32'h1111_1111, 4);
        chk("rdwr_is_store", last_out, 32'h0000_0500);
        do_op(32'h0000_0201, 32'h0000_1357, 1'b0, 1'b1, 2'b01, 1'b0, 32'd0, 0);
        do_op(32'h0000_0600, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 32'hCAFE_F00D, ACK_TIMEOUT - 1);
        chk("late_edge_ack", last_out, 32'hCAFE_F00D);
        do_op(32'h0000_0700, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0BAD_0BAD, ACK_TIMEOUT);

        // Reset in the middle of an access, then a stray ack after release.
        @(negedge clk);
        alu_result = 32'h0000_0400;
        mem_read   = 1'b1;
        size       = 2'b10;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        exp_addr  = 32'h0000_0400;
        exp_be    = 4'hF;
        exp_we    = 1'b0;
        exp_on    = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check_en = 1'b0;
        exp_on   = 1'b0;
        rst      = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_addr", dmem_addr, 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        check_en   = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        chk("rel_in_ready_high", {31'd0, in_ready}, 32'd1);
        repeat (5) @(negedge clk);
        do_op(32'h0000_0800, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h7777_8888, 2);
        chk("post_rst_load", last_out, 32'h7777_8888);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter: ACK_TIMEOUT, 16, max cycles waited for dmem_ack before abort (range 2..255).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  execute-stage result valid.
REQ-005 SHALL have port: in_ready  output  1  stage can accept (high only in IDLE).
REQ-006 SHALL have port: alu_result  input  32  ALU result, used as byte address for memory ops.
REQ-007 SHALL have port: store_data  input  32  store source, data in low bits.
REQ-008 SHALL have port: mem_read / mem_write  input  1 each  op is load / store.
REQ-009 SHALL have port: size  input  2  00 byte, 01 half, 10 and 11 word.
REQ-010 SHALL have port: sign_ext  input  1  sign-extend byte/half loads.
REQ-011 SHALL have port: dmem_req, dmem_we  output  1 each  memory request / write enable.
REQ-012 SHALL have port: dmem_addr  output  32  word address, bits [1:0] forced 0.
REQ-013 SHALL have port: dmem_wdata  output  32; dmem_be  output  4  byte enables.
REQ-014 SHALL have port: dmem_rdata  input  32; dmem_ack  input  1  completes request.
REQ-015 SHALL have port: out_valid  output  1  one-cycle result pulse; out_data  output  32  result.
REQ-016 SHALL have port: misaligned, bus_error  output  1 each  qualified by out_valid.

Function
REQ-017 SHALL implement FSM IDLE, ACCESS, RESP; accept = in_valid & in_ready, inputs captured on the accept edge.
REQ-018 SHALL, on accepting a non-memory op (mem_read=mem_write=0), go IDLE->RESP with out_data = alu_result (out_valid 1 cycle after accept).
REQ-019 SHALL treat mem_read=mem_write=1 as a store.
REQ-020 SHALL, on accepting a memory op, go IDLE->ACCESS holding dmem_req=1 and dmem_addr/we/be/wdata stable until the ack cycle.
REQ-021 SHALL use little-endian lanes: byte be=1<<addr[1:0], wdata = byte replicated x4; half be = addr[1]?1100:0011, wdata = half replicated x2; word be=1111.
REQ-022 SHALL, on dmem_ack in ACCESS, register the selected lane (zero- or sign-extended per sign_ext; word unchanged) into out_data for loads, alu_result for stores, go RESP, and drop dmem_req on the next cycle.
REQ-023 SHALL count ACCESS cycles; if ACK_TIMEOUT cycles pass with no ack, drop dmem_req, go RESP with bus_error=1, out_data=0.
REQ-024 SHALL assert out_valid for exactly one cycle in RESP, then return to IDLE; no back-pressure on out_valid.
REQ-025 SHALL ignore dmem_ack outside ACCESS.
REQ-026 SHALL keep misaligned and bus_error 0 except in the RESP cycle of the faulting op.

Reset
REQ-027 SHALL, while rst=0, immediately force state IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, out_valid=0, out_data=0, misaligned=0, bus_error=0, timeout counter=0.
REQ-028 SHALL drive in_ready=0 while rst=0, and 1 from the first clock after release.
REQ-029 SHALL abandon an in-flight access on reset; a late ack after release SHALL be ignored.

Configuration
REQ-030 SHALL, with MEM_ACCESS_ALIGN_CHECK_EN defined, flag half with addr[0]=1 or word with addr[1:0]!=0 as misaligned: no dmem_req, IDLE->RESP, misaligned=1, out_data=0.
REQ-031 SHALL, without MEM_ACCESS_ALIGN_CHECK_EN, never assert misaligned: half ignores addr[0], word ignores addr[1:0].

Verification
REQ-032 SHALL verify pass-through: alu_result=0x0000_1234, no mem op -> out_valid next cycle, out_data=0x0000_1234, no dmem_req.
REQ-033 SHALL verify signed byte load: addr 0x103, size 00, sign_ext=1, ack after 3 cycles with rdata 0x80_00_00_00 -> dmem_addr 0x100, be 1000, out_data 0xFFFF_FF80.
REQ-034 SHALL verify half store: addr 0x202, store_data 0xABCD -> be 1100, wdata 0xABCD_ABCD, we=1, out_data 0x202.
REQ-035 SHALL verify timeout: word load, no ack -> dmem_req drops after 16 cycles, out_valid with bus_error=1, out_data=0.
REQ-036 SHALL verify misaligned (macro on): word at 0x2 -> no dmem_req, misaligned=1; (macro off) -> access to 0x0 with be 1111.
REQ-037 SHALL verify reset mid-ACCESS: rst low -> dmem_req 0 immediately; ack after release -> no out_valid.
